// File: rtl/xadc_capture_ctrl.sv
// Trigger/capture sequencer between the XADC DRP read port and the 640-entry VGA sample RAM.
// Define AUTO_TRIG_EN to force a trigger after AUTO_TIMEOUT accepted samples without a hit.
`timescale 1ns/1ps
module xadc_capture_ctrl #(
    parameter int DEPTH        = 640,
    parameter int AW           = 10,
    parameter int HOLD_FRAMES  = 2,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic          CLK100MHZ,
    input  logic          CPU_RESETN,
    input  logic          sample_valid,
    input  logic [15:0]   sample_data,
    input  logic          run,
    input  logic          single,
    input  logic          slope,
    input  logic [11:0]   trig_level,
    input  logic [7:0]    decim,
    input  logic          frame_tick,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [15:0]   wr_data,
    output logic [2:0]    state,
    output logic          capture_done,
    output logic          frame_valid,
    output logic          auto_trig
);
`ifdef AUTO_TRIG_EN
    localparam bit AUTO_EN = 1'b1;
`else
    localparam bit AUTO_EN = 1'b0;
`endif
    localparam int            HW           = $clog2(HOLD_FRAMES + 1);
    localparam int            TW           = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [AW-1:0] LAST_ADDR    = AW'(DEPTH - 1);
    localparam logic [HW-1:0] HOLD_LAST    = HW'(HOLD_FRAMES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(AUTO_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARM  = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t          st;
    logic [7:0]      dec_cnt;
    logic [11:0]     prev;
    logic [AW-1:0]   next_addr;
    logic [HW-1:0]   hold_cnt;
    logic [TW-1:0]   wait_cnt;
    logic            single_latch;

    logic [11:0]     v;
    logic            accepted;
    logic            hit;
    logic            timeout;
    logic            last_write;

    always_comb begin
        v          = sample_data[15:4];
        accepted   = sample_valid && (dec_cnt == 8'd0);
        hit        = slope ? ((prev > trig_level) && (v <= trig_level))
                           : ((prev < trig_level) && (v >= trig_level));
        timeout    = AUTO_EN && !hit && (wait_cnt == TIMEOUT_LAST);
        last_write = (next_addr == LAST_ADDR);
    end

    assign state = st;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            st           <= S_IDLE;
            dec_cnt      <= '0;
            prev         <= '0;
            next_addr    <= '0;
            hold_cnt     <= '0;
            wait_cnt     <= '0;
            single_latch <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            capture_done <= 1'b0;
            frame_valid  <= 1'b0;
            auto_trig    <= 1'b0;
        end else begin
            wr_en        <= 1'b0;
            capture_done <= 1'b0;
            if (sample_valid)
                dec_cnt <= (dec_cnt >= decim) ? 8'd0 : dec_cnt + 8'd1;
            if (!run)
                single_latch <= 1'b0;

            case (st)
                S_IDLE: begin
                    if (run && !single_latch) begin
                        st      <= S_ARM;
                        dec_cnt <= '0;
                    end
                end
                S_ARM: begin
                    if (!run) begin
                        st <= S_IDLE;
                    end else if (accepted) begin
                        prev     <= v;
                        wait_cnt <= '0;
                        st       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Abort has priority over a hit arriving in the same cycle.
                    if (!run) begin
                        st <= S_IDLE;
                    end else if (accepted) begin
                        if (hit || timeout) begin
                            wr_en       <= 1'b1;
                            wr_addr     <= '0;
                            wr_data     <= sample_data;
                            next_addr   <= AW'(1);
                            frame_valid <= 1'b0;
                            auto_trig   <= timeout;
                            st          <= S_CAPT;
                        end else begin
                            prev     <= v;
                            wait_cnt <= wait_cnt + TW'(1);
                        end
                    end
                end
                S_CAPT: begin
                    // The final write is allowed to land even when run drops with it.
                    if (accepted && (run || last_write)) begin
                        wr_en   <= 1'b1;
                        wr_addr <= next_addr;
                        wr_data <= sample_data;
                        if (last_write) begin
                            capture_done <= 1'b1;
                            frame_valid  <= 1'b1;
                            if (single)
                                single_latch <= 1'b1;
                            if (single || !run) begin
                                st <= S_IDLE;
                            end else begin
                                st       <= S_HOLD;
                                hold_cnt <= '0;
                            end
                        end else begin
                            next_addr <= next_addr + AW'(1);
                        end
                    end else if (!run) begin
                        st <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (!run) begin
                        st <= S_IDLE;
                    end else if (frame_tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            st      <= S_ARM;
                            dec_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xadc_capture_ctrl.sv
// Self-checking bench for xadc_capture_ctrl: directed scenarios plus a random soak,
// all checked cycle by cycle against a transaction-level model of the capture sequence.
`timescale 1ns/1ps
module tb_xadc_capture_ctrl;
    localparam int DEPTH        = 640;
    localparam int AW           = 10;
    localparam int HOLD_FRAMES  = 2;
    localparam int AUTO_TIMEOUT = 4096;
    localparam int W            = AW + 16;
`ifdef AUTO_TRIG_EN
    localparam bit AUTO_ON = 1'b1;
`else
    localparam bit AUTO_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic CLK100MHZ  = 1'b0;
    logic CPU_RESETN = 1'b0;
    always #5 CLK100MHZ = ~CLK100MHZ;

    logic          sample_valid = 1'b0;
    logic [15:0]   sample_data  = '0;
    logic          run          = 1'b0;
    logic          single       = 1'b0;
    logic          slope        = 1'b0;
    logic [11:0]   trig_level   = '0;
    logic [7:0]    decim        = '0;
    logic          frame_tick   = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic [2:0]    state;
    logic          capture_done;
    logic          frame_valid;
    logic          auto_trig;

    xadc_capture_ctrl #(
        .DEPTH(DEPTH), .AW(AW), .HOLD_FRAMES(HOLD_FRAMES), .AUTO_TIMEOUT(AUTO_TIMEOUT)
    ) dut (
        .CLK100MHZ(CLK100MHZ), .CPU_RESETN(CPU_RESETN),
        .sample_valid(sample_valid), .sample_data(sample_data),
        .run(run), .single(single), .slope(slope), .trig_level(trig_level),
        .decim(decim), .frame_tick(frame_tick),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .state(state),
        .capture_done(capture_done), .frame_valid(frame_valid), .auto_trig(auto_trig)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int n_done  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Acceptance is "sample index since arming is a multiple of decim+1"; a capture is the
    // count of samples already stored; hold is the count of frame ticks seen.
    int           m_mode  = 0;
    int           m_sv    = 0;
    int           m_kept  = 0;
    int           m_wait  = 0;
    int           m_ticks = 0;
    logic [11:0]  m_prev  = '0;
    bit           m_latch = 1'b0;
    logic         e_wr_en = 1'b0;
    logic         e_done  = 1'b0;
    logic         e_fv    = 1'b0;
    logic         e_auto  = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic model_write(input int addr);
        e_wr_en = 1'b1;
        exp_q.push_back({AW'(addr), sample_data});
    endtask

    task automatic model_step();
        logic [11:0] v;
        bit acc, hit, forced;
        v      = sample_data[15:4];
        acc    = sample_valid && ((m_sv % (int'(decim) + 1)) == 0);
        e_wr_en = 1'b0;
        e_done  = 1'b0;
        if (sample_valid) m_sv++;
        if (!run) m_latch = 1'b0;
        case (m_mode)
            0: if (run && !m_latch) begin m_mode = 1; m_sv = 0; end
            1: if (!run) m_mode = 0;
               else if (acc) begin m_prev = v; m_wait = 0; m_mode = 2; end
            2: if (!run) m_mode = 0;
               else if (acc) begin
                   hit = slope ? (m_prev > trig_level && v <= trig_level)
                               : (m_prev < trig_level && v >= trig_level);
                   m_wait++;
                   forced = AUTO_ON && !hit && (m_wait == AUTO_TIMEOUT);
                   if (hit || forced) begin
                       model_write(0);
                       m_kept = 1; e_fv = 1'b0; e_auto = forced; m_mode = 3;
                   end else begin
                       m_prev = v;
                   end
               end
            3: if (acc && (run || m_kept == DEPTH - 1)) begin
                   model_write(m_kept);
                   m_kept++;
                   if (m_kept == DEPTH) begin
                       e_done = 1'b1; e_fv = 1'b1;
                       if (single) m_latch = 1'b1;
                       if (single || !run) m_mode = 0;
                       else begin m_mode = 4; m_ticks = 0; end
                   end
               end else if (!run) m_mode = 0;
            4: if (!run) m_mode = 0;
               else if (frame_tick) begin
                   m_ticks++;
                   if (m_ticks == HOLD_FRAMES) begin m_mode = 1; m_sv = 0; end
               end
            default: m_mode = 0;
        endcase
    endtask

    always @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            m_mode = 0; m_sv = 0; m_kept = 0; m_wait = 0; m_ticks = 0;
            m_prev = '0; m_latch = 1'b0;
            e_wr_en = 1'b0; e_done = 1'b0; e_fv = 1'b0; e_auto = 1'b0;
            exp_q.delete();
        end else begin
            model_step();
        end
    end

    // ---------------- scoreboard: compare every cycle ----------------
    logic [W-1:0] exp_w;
    always @(negedge CLK100MHZ) begin
        check("outputs{state,wr_en,done,fv,auto}",
              {state, wr_en, capture_done, frame_valid, auto_trig},
              {3'(m_mode), e_wr_en, e_done, e_fv, e_auto});
        if (wr_en) begin
            n_wr++;
            check("wr_expected", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                check("wr_addr_data", {wr_addr, wr_data}, exp_w);
            end
        end
        if (capture_done) n_done++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK100MHZ);
        #1;
    endtask

    task automatic settle();
        @(negedge CLK100MHZ);
        #1;
    endtask

    task automatic send(input logic [11:0] v, input int gap);
        sample_valid = 1'b1;
        sample_data  = {v, 4'($urandom_range(0, 15))};
        tick();
        sample_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic frame_pulse();
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
    endtask

    task automatic send_random(input int n, input int max_gap);
        for (int i = 0; i < n; i++) send(12'($urandom), $urandom_range(0, max_gap));
    endtask

    task automatic run_cycle();
        run = 1'b0;
        tick();
        run = 1'b1;
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done_save, off;
        repeat (3) tick();
        check("reset_outputs", {wr_en, wr_addr, wr_data, state, capture_done, frame_valid, auto_trig}, 64'd0);
        CPU_RESETN = 1'b1;

        // Rising trigger on a ramp, full capture.
        decim = 8'd0; trig_level = 12'h800; slope = 1'b0; single = 1'b0; run = 1'b1;
        tick();
        check("t1_arm_state", state, 64'd1);
        send(12'h7F0, 0);
        send(12'h7F8, 0);
        check("t1_no_early_write", wr_en, 64'd0);
        n_wr = 0; n_done = 0;
        send(12'h800, 0);
        check("t1_first_write", {wr_en, wr_addr, wr_data[15:4]}, {1'b1, 10'd0, 12'h800});
        check("t1_capt_state", state, 64'd3);
        send_random(DEPTH - 1, 2);
        check("t1_last_addr", wr_addr, 64'd639);
        settle();
        check("t1_write_count", n_wr, 64'd640);
        check("t1_done_count", n_done, 64'd1);
        check("t1_frame_valid", frame_valid, 64'd1);
        check("t1_hold_state", state, 64'd4);

        // Decimation and hold.
        decim = 8'd3;
        n_wr = 0; n_done = 0;
        send_random(5, 1);
        frame_pulse();
        check("t2_hold_after_1_tick", state, 64'd4);
        frame_pulse();
        check("t2_arm_after_2_ticks", state, 64'd1);
        repeat (4) send(12'h100, 0);
        check("t2_wait_state", state, 64'd2);
        send(12'h900, 0);
        check("t2_first_write", {wr_en, wr_addr}, {1'b1, 10'd0});
        repeat (3) send(12'h900, 1);
        for (int g = 0; g < DEPTH - 2; g++) send_random(4, 1);
        settle();
        check("t2_writes_before_last_group", n_wr, 64'd639);
        check("t2_no_done_yet", n_done, 64'd0);
        send_random(4, 1);
        settle();
        check("t2_writes_total", n_wr, 64'd640);
        check("t2_done_count", n_done, 64'd1);

        // Falling slope, strict threshold.
        decim = 8'd0; slope = 1'b1; trig_level = 12'h400;
        frame_pulse();
        frame_pulse();
        check("t3_arm_state", state, 64'd1);
        send(12'h400, 0);
        send(12'h400, 0);
        check("t3_equal_no_trigger", {wr_en, state}, {1'b0, 3'd2});
        send(12'h500, 0);
        check("t3_above_no_trigger", {wr_en, state}, {1'b0, 3'd2});
        single = 1'b1;
        n_wr = 0; n_done = 0;
        send(12'h400, 0);
        check("t3_falling_write", {wr_en, wr_addr, wr_data[15:4]}, {1'b1, 10'd0, 12'h400});

        // Single shot: stop in IDLE, re-arm only after a run toggle.
        send_random(DEPTH - 1, 1);
        repeat (6) tick();
        check("t4_idle_after_single", state, 64'd0);
        check("t4_done_count", n_done, 64'd1);
        check("t4_frame_valid", frame_valid, 64'd1);
        run_cycle();
        check("t4_rearm_state", state, 64'd1);
        send(12'h500, 0);
        send(12'h300, 0);
        check("t4_second_trigger", {wr_en, wr_addr}, {1'b1, 10'd0});
        send_random(DEPTH - 1, 1);
        tick();
        settle();
        check("t4_second_done", n_done, 64'd2);
        check("t4_second_idle", state, 64'd0);

        // Mid-capture abort after the write to address 300.
        single = 1'b0;
        run_cycle();
        send(12'h500, 0);
        send(12'h300, 0);
        for (int i = 0; i < 300; i++) send(12'($urandom), 0);
        check("t5_write_300", {wr_en, wr_addr}, {1'b1, 10'd300});
        done_save = n_done;
        run = 1'b0;
        sample_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            sample_data = 16'($urandom);
            tick();
            check("t5_abort_outputs", {wr_en, state, frame_valid}, {1'b0, 3'd0, 1'b0});
        end
        sample_valid = 1'b0;
        settle();
        check("t5_no_done_after_abort", n_done, 64'(done_save));

        // Asynchronous reset in the middle of a capture.
        run = 1'b1;
        tick();
        send(12'h500, 0);
        send(12'h300, 0);
        send_random(20, 0);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check("t5_async_reset", {wr_en, wr_addr, wr_data, state, capture_done, frame_valid, auto_trig}, 64'd0);
        run = 1'b0;
        repeat (2) tick();
        CPU_RESETN = 1'b1;

        // Flat input: forced trigger only with AUTO_TRIG_EN.
        decim = 8'd0; slope = 1'b0; trig_level = 12'h800;
        tick();
        run = 1'b1;
        tick();
        check("t6_arm_state", state, 64'd1);
        n_wr = 0;
        send(12'h100, 0);
`ifdef AUTO_TRIG_EN
        for (int i = 0; i < AUTO_TIMEOUT - 1; i++) send(12'h100, $urandom_range(0, 1));
        settle();
        check("t6_no_write_before_timeout", n_wr, 64'd0);
        send(12'h100, 0);
        check("t6_forced_write", {wr_en, wr_addr, auto_trig}, {1'b1, 10'd0, 1'b1});
`else
        for (int i = 0; i < 10000; i++) send(12'h100, 0);
        settle();
        check("t6_no_write_flat", n_wr, 64'd0);
        check("t6_still_waiting", {state, auto_trig}, {3'd2, 1'b0});
`endif

        // Random soak.
        off = 0;
        for (int c = 0; c < 25000; c++) begin
            sample_valid = ($urandom_range(0, 1) == 1);
            sample_data  = 16'($urandom);
            frame_tick   = ($urandom_range(0, 39) == 0);
            trig_level   = 12'h800;
            if (run && $urandom_range(0, 2999) == 0) begin
                run = 1'b0;
                off = $urandom_range(2, 6);
            end else if (!run) begin
                if (off == 1) begin
                    decim  = 8'($urandom_range(0, 2));
                    slope  = 1'($urandom_range(0, 1));
                    single = ($urandom_range(0, 3) == 0);
                end
                off--;
                if (off <= 0) run = 1'b1;
            end
            tick();
        end
        sample_valid = 1'b0;
        frame_tick   = 1'b0;
        run          = 1'b0;
        repeat (3) tick();
        check("end_queue_drained", exp_q.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time bound");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/xadc_capture_ctrl.md
Name: xadc_capture_ctrl

Overview:
Trigger/capture sequencer between the XADC DRP read port (DRDY/DO) and the 640-entry dual-port sample RAM read by the VGA plotter. Arms on an edge trigger with optional decimation, then writes exactly DEPTH samples starting at address 0, so the trigger point sits at x=0. After a capture it holds the RAM stable for a set number of video frames before re-arming. Run and single-shot control come from switches and buttons. The block replaces free-running address generation.

Parameters:
DEPTH, 640, samples per capture; RAM addresses 0..DEPTH-1.
AW, 10, write-address width.
HOLD_FRAMES, 2, frame_tick pulses to wait in HOLD before re-arm (minimum 1).
AUTO_TIMEOUT, 4096, accepted samples in WAIT_TRIG before forced trigger (AUTO_TRIG_EN only).

Ports:
CLK100MHZ  in  1  system clock
CPU_RESETN  in  1  reset
sample_valid  in  1  XADC drdy, 1-cycle pulse
sample_data  in  16  XADC do_out; value = bits[15:4]
run  in  1  level; 0 forces IDLE
single  in  1  level; 1 = stop in IDLE after one capture
slope  in  1  0 rising, 1 falling
trig_level  in  12  trigger threshold
decim  in  8  keep 1 of every decim+1 accepted samples
frame_tick  in  1  1-cycle pulse per video frame (vsync start)
wr_en  out  1  RAM write enable
wr_addr  out  AW  RAM write address
wr_data  out  16  RAM write data
state  out  3  IDLE=0 ARM=1 WAIT=2 CAPT=3 HOLD=4
capture_done  out  1  1-cycle pulse after last write
frame_valid  out  1  RAM holds a complete capture
auto_trig  out  1  last capture was forced by timeout

Behaviour:
- Reset is CPU_RESETN, asynchronous, active-low; clock is CLK100MHZ. On reset: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, capture_done=0, frame_valid=0, auto_trig=0, and all internal counters are 0.
- Accepted sample: sample_valid=1 and the decimation counter is 0. The counter increments on each sample_valid and wraps from decim to 0. The counter clears on entry to ARM. decim=0 accepts every sample.
- v = sample_data[15:4]. prev holds the v of the previous accepted sample.
- Rising hit: prev < trig_level and v >= trig_level. Falling hit: prev > trig_level and v <= trig_level. All comparisons are unsigned 12-bit.
- IDLE: when run=1 and the single-latch is clear, go to ARM. The single-latch sets on capture completion while single=1 and clears when run=0.
- ARM: the first accepted sample loads prev, then go to WAIT. No write occurs.
- WAIT: on a hit, write the sample to address 0 and go to CAPT with the next address = 1. frame_valid clears on this transition. Otherwise update prev.
- CAPT: each accepted sample is written at the next address, and the address increments. The write to DEPTH-1 ends the capture: pulse capture_done and set frame_valid. If single=1, go to IDLE, else go to HOLD.
- HOLD: count frame_tick pulses. At HOLD_FRAMES, go to ARM. Samples are ignored.
- Write latency: wr_en, wr_addr and wr_data are registered and valid exactly 1 cycle after the accepting sample_valid cycle. wr_en is high for 1 cycle per write and is never high outside WAIT→CAPT or CAPT.
- run=0 in any state: go to IDLE on the next cycle. Any write already registered that cycle completes. A write at address DEPTH-1 is never issued after the abort. The RAM keeps partial data, and frame_valid stays 0 if the abort came during CAPT.
- Simultaneous events:
  - frame_tick in CAPT is ignored.
  - A hit and run=0 in the same cycle: abort wins, no write.
  - A capture ending and run=0 in the same cycle: the write completes, capture_done pulses, then IDLE.
- wr_addr never exceeds DEPTH-1, and there is no wrap within a capture.

Optional Feature:
AUTO_TRIG_EN defined:
- In WAIT, count accepted samples.
- When the count reaches AUTO_TIMEOUT without a hit, treat the sample as a hit and set auto_trig=1.
- auto_trig clears on the next genuine hit.
- The counter clears on entry to WAIT.

AUTO_TRIG_EN undefined:
- WAIT waits indefinitely.
- auto_trig is tied to 0.

Test Plan:
1. Hit and capture: decim=0, trig_level=0x800, slope=0, ramp v=0x7F0,0x7F8,0x800,... → first wr_en at addr 0 with v=0x800, 1 cycle after that sample_valid. Exactly 640 writes, addresses 0..639. capture_done pulses once, and frame_valid=1.
2. Decimation and hold: decim=3 gives one write per 4 sample_valid pulses. In HOLD, 1 frame_tick keeps state=4, and the 2nd frame_tick gives state=1.
3. Falling slope and threshold: slope=1, level=0x400, samples 0x500,0x400 → trigger on 0x400. The sequence 0x400,0x400 does not trigger, because prev must be strictly greater than the level.
4. Single shot: single=1, run=1 → one capture then IDLE. Toggling run 0→1 yields a second capture.
5. Mid-capture abort: deassert run after the write to addr 300 → wr_en stays 0 from the next cycle, state=0, frame_valid=0, no capture_done. Assert CPU_RESETN low during CAPT → all outputs go to 0 asynchronously.
6. AUTO_TRIG_EN with flat input 0x100, AUTO_TIMEOUT=4096 → the write at addr 0 occurs on the 4096th accepted sample in WAIT, and auto_trig=1. Without the macro, no write occurs after 10000 samples.
